noc_ni_param: RTL and testbench
===============================

// Module: noc_ni_param
// PURPOSE
//  Parametrised processor<->NoC network interface, successor to the fixed 8-bit NI.
//  TX path: packetises one DATA_W word into a header flit, 1..NFLITS data flits and a tail flit.
//    Trailing all-zero data flits are suppressed.
//  RX path: depacketises and zero-fills the suppressed flits.
//  Both NoC links use valid/ready with an explicit last sideband. Tail is no longer detected by flit value.
// PARAMETERS
//  FLIT_W   8          flit width, bits
//  DATA_W   32         payload width; DATA_W % FLIT_W == 0; NFLITS = DATA_W/FLIT_W
//  ADDR_W   2          destination/source address width; ADDR_W < FLIT_W
//  HDR_TAG  6'b101111  header tag, width FLIT_W-ADDR_W; header = {HDR_TAG, addr}
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, asynchronous, active-high
//  p_tx_valid  in   1        processor word valid
//  p_tx_ready  out  1        NI can accept a word
//  p_tx_dest   in   ADDR_W   destination address
//  p_tx_data   in   DATA_W   payload
//  n_tx_flit   out  FLIT_W   flit to router
//  n_tx_valid  out  1        flit valid
//  n_tx_last   out  1        flit is tail
//  n_tx_ready  in   1        router accepts flit
//  n_rx_flit   in   FLIT_W   flit from router
//  n_rx_valid  in   1        flit valid
//  n_rx_last   in   1        flit is tail
//  n_rx_ready  out  1        NI accepts flit
//  p_rx_valid  out  1        received word valid
//  p_rx_ready  in   1        processor accepts word
//  p_rx_data   out  DATA_W   received payload, LSB flit first
//  p_rx_src    out  ADDR_W   address field of received header
//  p_rx_err    out  1        packet error; qualified by p_rx_valid
// BEHAVIOUR
//  Reset values: p_tx_ready=1, n_tx_valid=0, n_tx_last=0, n_rx_ready=1, p_rx_valid=0,
//    p_rx_data=0, p_rx_src=0, p_rx_err=0.
//  Reset mid-packet abandons the packet immediately; no tail flit is emitted.
//  Handshake: transfer occurs on valid&&ready. All outputs are held stable while valid&&!ready.
//  TX FSM: IDLE -> HEAD -> DATA -> TAIL -> IDLE.
//   IDLE: p_tx_ready=1. On accept, latch dest and data.
//     used = index of highest nonzero flit + 1; minimum 1 (data==0 sends one 0x00 flit).
//   HEAD: drive header, valid=1, last=0. On handshake -> DATA with idx=0.
//   DATA: drive data[idx*FLIT_W +: FLIT_W]. On handshake: idx==used-1 -> TAIL, else idx++.
//   TAIL: drive tail flit with last=1. On handshake -> IDLE.
//   Timing: p_tx_ready=0 from the accept cycle until the tail handshake.
//     Minimum occupancy = used+3 cycles.
//  RX FSM: R_HEAD, R_DATA, R_DROP, R_DONE.
//   n_rx_ready=1 in R_HEAD, R_DATA and R_DROP; 0 in R_DONE.
//   R_HEAD, on handshake:
//     tag==HDR_TAG and !last -> store src; cnt=0; clear buffer and err; -> R_DATA.
//     bad tag and !last -> R_DROP.
//     last=1 -> flit discarded; stay in R_HEAD.
//   R_DATA, non-last flit: cnt<NFLITS -> store at slot cnt; cnt++.
//     Otherwise set err (overflow) and discard the flit.
//   R_DATA, last flit (tail): cnt==0 -> set err. Then -> R_DONE.
//   R_DROP: consume flits until last=1, then -> R_HEAD. Never raises p_rx_valid.
//   R_DONE: p_rx_valid=1, data/src/err held stable. On p_rx_ready -> R_HEAD.
//   Unwritten payload slots read 0. TX and RX paths are fully independent.
// CONFIGURATION
//  NI_CKSUM_EN defined:
//    TX tail = XOR of header and all transmitted data flits.
//    RX XORs header and data flits, compares with tail; mismatch sets p_rx_err.
//  NI_CKSUM_EN undefined: TX tail = all-ones; RX ignores tail content.
// STRUCTURE
//  noc_ni_pkg: TX/RX state enums, TAIL_FLIT constant, flit_xor() checksum function, NFLITS helper.
//  Sub-module noc_ni_rx holds the receive FSM and buffer. TX FSM stays in noc_ni_param.
// TESTING  (FLIT_W=8, DATA_W=32, ADDR_W=2)
//  T1 dest=2, data=0x11223344, n_tx_ready=1
//     -> flits BE,44,33,22,11,FF(last); with NI_CKSUM_EN tail=FA.
//  T2 dest=0, data=0x00000055 -> BC,55,tail; data=0 -> BC,00,tail; p_tx_ready low throughout.
//  T3 drop n_tx_ready for 3 cycles at idx=1 -> n_tx_flit=33 held stable; no flit lost or duplicated.
//  T4 RX BD,AA,BB,FF(last) -> p_rx_data=0x0000BBAA, src=1, err=0.
//     Hold p_rx_ready=0 -> n_rx_ready=0 until released.
//  T5 RX BC + 5 data flits + tail -> err=1, data = first 4 flits.
//     RX header 0x00 + 2 flits + tail -> no p_rx_valid; next good packet received intact.
//  T6 assert rst mid-TX DATA and mid-RX -> all outputs at reset values next cycle;
//     next packet correct; cksum mismatch (tail^0x01) -> err=1.

Source files
------------

// File: rtl/noc_ni_pkg.sv
// Shared types and helpers for the parametrised processor<->NoC network interface.
// TX/RX state encodings, the default tail flit, the flit checksum fold and the
// flits-per-word helper live here so both paths agree on them.
package noc_ni_pkg;

   // Widest flit the checksum helper handles; callers zero-extend and truncate.
   localparam int FLIT_MAX = 64;

   // Tail flit sent when the checksum option is not built in (truncated to FLIT_W).
   localparam logic [FLIT_MAX-1:0] TAIL_FLIT = '1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_HEAD,
      TX_DATA,
      TX_TAIL
   } tx_state_t;

   typedef enum logic [1:0] {
      R_HEAD,
      R_DATA,
      R_DROP,
      R_DONE
   } rx_state_t;

   // Number of flits carrying one payload word.
   function automatic int nflits(input int data_w, input int flit_w);
      return data_w / flit_w;
   endfunction

   // Running checksum: fold one more flit into the accumulator.
   function automatic logic [FLIT_MAX-1:0] flit_xor(input logic [FLIT_MAX-1:0] acc,
                                                    input logic [FLIT_MAX-1:0] flit);
      return acc ^ flit;
   endfunction

endpackage

// File: rtl/noc_ni_param_if.sv
// Bundle of the processor-side and NoC-side handshake signals of the NI.
// slave = the network interface itself, master = processor + router side.
interface noc_ni_param_if #(
   parameter int FLIT_W = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   // processor -> NI word
   logic              p_tx_valid;
   logic              p_tx_ready;
   logic [ADDR_W-1:0] p_tx_dest;
   logic [DATA_W-1:0] p_tx_data;
   // NI -> router flits
   logic [FLIT_W-1:0] n_tx_flit;
   logic              n_tx_valid;
   logic              n_tx_last;
   logic              n_tx_ready;
   // router -> NI flits
   logic [FLIT_W-1:0] n_rx_flit;
   logic              n_rx_valid;
   logic              n_rx_last;
   logic              n_rx_ready;
   // NI -> processor word
   logic              p_rx_valid;
   logic              p_rx_ready;
   logic [DATA_W-1:0] p_rx_data;
   logic [ADDR_W-1:0] p_rx_src;
   logic              p_rx_err;

   modport slave (
      input  p_tx_valid, p_tx_dest, p_tx_data, n_tx_ready,
             n_rx_flit, n_rx_valid, n_rx_last, p_rx_ready,
      output p_tx_ready, n_tx_flit, n_tx_valid, n_tx_last,
             n_rx_ready, p_rx_valid, p_rx_data, p_rx_src, p_rx_err
   );

   modport master (
      output p_tx_valid, p_tx_dest, p_tx_data, n_tx_ready,
             n_rx_flit, n_rx_valid, n_rx_last, p_rx_ready,
      input  p_tx_ready, n_tx_flit, n_tx_valid, n_tx_last,
             n_rx_ready, p_rx_valid, p_rx_data, p_rx_src, p_rx_err
   );

endinterface

// File: rtl/noc_ni_rx.sv
// Receive path of the NI: depacketises header/data/tail flits into one word,
// zero-filling slots that were suppressed by the sender.
// Optional macro NI_CKSUM_EN: the tail carries the XOR of header and data
// flits and a mismatch raises p_rx_err; otherwise tail content is ignored.
module noc_ni_rx
   import noc_ni_pkg::*;
#(
   parameter int                         FLIT_W  = 8,
   parameter int                         DATA_W  = 32,
   parameter int                         ADDR_W  = 2,
   parameter logic [FLIT_W-ADDR_W-1:0]   HDR_TAG = 6'b101111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] n_rx_flit,
   input  logic              n_rx_valid,
   input  logic              n_rx_last,
   output logic              n_rx_ready,
   output logic              p_rx_valid,
   input  logic              p_rx_ready,
   output logic [DATA_W-1:0] p_rx_data,
   output logic [ADDR_W-1:0] p_rx_src,
   output logic              p_rx_err
);

   localparam int               NFLITS = nflits(DATA_W, FLIT_W);
   localparam int               CNT_W  = $clog2(NFLITS + 1);
   localparam logic [CNT_W-1:0] NF_C   = CNT_W'(NFLITS);

   rx_state_t         rx_state, rx_next;
   logic [ADDR_W-1:0] src_q;
   logic [DATA_W-1:0] buf_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              hdr_ok;
   logic              rx_fire;
`ifdef NI_CKSUM_EN
   logic [FLIT_W-1:0] cks_q;
`endif

   assign hdr_ok  = (n_rx_flit[FLIT_W-1:ADDR_W] == HDR_TAG);
   assign rx_fire = n_rx_valid && n_rx_ready;

   // State register; reset abandons any packet in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_state <= R_HEAD;
      else     rx_state <= rx_next;
   end

   // Next-state decode from the flit sideband and the processor handshake.
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_HEAD: if (n_rx_valid && !n_rx_last) rx_next = hdr_ok ? R_DATA : R_DROP;
         R_DATA: if (n_rx_valid && n_rx_last)  rx_next = R_DONE;
         R_DROP: if (n_rx_valid && n_rx_last)  rx_next = R_HEAD;
         R_DONE: if (p_rx_ready)               rx_next = R_HEAD;
         default: rx_next = R_HEAD;
      endcase
   end

   // Handshake outputs: the NI only stalls the router while a word waits for the processor.
   always_comb begin
      n_rx_ready = (rx_state != R_DONE);
      p_rx_valid = (rx_state == R_DONE);
   end

   // Payload buffer, source, error flag and slot counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q <= '0;
         buf_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
`ifdef NI_CKSUM_EN
         cks_q <= '0;
`endif
      end else if (rx_fire) begin
         case (rx_state)
            R_HEAD: begin
               if (!n_rx_last && hdr_ok) begin
                  src_q <= n_rx_flit[ADDR_W-1:0];
                  buf_q <= '0;
                  err_q <= 1'b0;
                  cnt_q <= '0;
`ifdef NI_CKSUM_EN
                  cks_q <= n_rx_flit;
`endif
               end
            end
            R_DATA: begin
               if (!n_rx_last) begin
                  if (cnt_q < NF_C) begin
                     for (int i = 0; i < NFLITS; i++)
                        if (cnt_q == CNT_W'(i)) buf_q[i*FLIT_W +: FLIT_W] <= n_rx_flit;
                     cnt_q <= cnt_q + CNT_W'(1);
`ifdef NI_CKSUM_EN
                     cks_q <= FLIT_W'(flit_xor(FLIT_MAX'(cks_q), FLIT_MAX'(n_rx_flit)));
`endif
                  end else begin
                     // More data flits than a word holds: keep the first NFLITS.
                     err_q <= 1'b1;
                  end
               end else begin
                  if (cnt_q == '0) err_q <= 1'b1;
`ifdef NI_CKSUM_EN
                  if (n_rx_flit != cks_q) err_q <= 1'b1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign p_rx_data = buf_q;
   assign p_rx_src  = src_q;
   assign p_rx_err  = err_q;

endmodule

// File: rtl/noc_ni_param.sv
// Parametrised processor<->NoC network interface.
// TX: one DATA_W word becomes header, 1..NFLITS data flits (trailing zero
// flits suppressed) and a tail flit flagged by n_tx_last.
// RX: handled by noc_ni_rx.
// Optional macro NI_CKSUM_EN: tail flit carries XOR of header and data flits;
// without it the tail is all-ones.
module noc_ni_param
   import noc_ni_pkg::*;
#(
   parameter int                         FLIT_W  = 8,
   parameter int                         DATA_W  = 32,
   parameter int                         ADDR_W  = 2,
   parameter logic [FLIT_W-ADDR_W-1:0]   HDR_TAG = 6'b101111
) (
   input logic           clk,
   input logic           rst,
   noc_ni_param_if.slave bus
);

   localparam int NFLITS = nflits(DATA_W, FLIT_W);
   localparam int CNT_W  = $clog2(NFLITS + 1);

   tx_state_t         tx_state, tx_next;
   logic [ADDR_W-1:0] dest_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  used_q;
   logic [CNT_W-1:0]  idx_q;
   logic [CNT_W-1:0]  used_w;
   logic              idx_last;
   logic              tx_accept;
   logic [FLIT_W-1:0] hdr_flit;
   logic [FLIT_W-1:0] data_flit;
   logic [FLIT_W-1:0] tail_flit;

   assign tx_accept = (tx_state == TX_IDLE) && bus.p_tx_valid;
   assign idx_last  = (idx_q == used_q - CNT_W'(1));
   assign hdr_flit  = {HDR_TAG, dest_q};

   // Flits actually sent: highest nonzero flit index + 1, never fewer than one.
   always_comb begin
      used_w = CNT_W'(1);
      for (int i = 0; i < NFLITS; i++)
         if (bus.p_tx_data[i*FLIT_W +: FLIT_W] != '0) used_w = CNT_W'(i + 1);
   end

   // Select the data flit addressed by idx_q.
   always_comb begin
      data_flit = '0;
      for (int i = 0; i < NFLITS; i++)
         if (idx_q == CNT_W'(i)) data_flit = data_q[i*FLIT_W +: FLIT_W];
   end

`ifdef NI_CKSUM_EN
   // Tail is the XOR of the header and every data flit that goes on the wire.
   always_comb begin
      tail_flit = hdr_flit;
      for (int i = 0; i < NFLITS; i++)
         if (CNT_W'(i) < used_q)
            tail_flit = FLIT_W'(flit_xor(FLIT_MAX'(tail_flit),
                                         FLIT_MAX'(data_q[i*FLIT_W +: FLIT_W])));
   end
`else
   assign tail_flit = FLIT_W'(TAIL_FLIT);
`endif

   // TX state register; reset drops a packet mid-flight without a tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_next;
   end

   // TX next state: each flit advances only on its router handshake.
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE: if (bus.p_tx_valid)              tx_next = TX_HEAD;
         TX_HEAD: if (bus.n_tx_ready)              tx_next = TX_DATA;
         TX_DATA: if (bus.n_tx_ready && idx_last)  tx_next = TX_TAIL;
         TX_TAIL: if (bus.n_tx_ready)              tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   // TX outputs decoded purely from state and latched word, so they hold under stall.
   always_comb begin
      bus.p_tx_ready = (tx_state == TX_IDLE);
      bus.n_tx_valid = (tx_state != TX_IDLE);
      bus.n_tx_last  = (tx_state == TX_TAIL);
      case (tx_state)
         TX_HEAD: bus.n_tx_flit = hdr_flit;
         TX_DATA: bus.n_tx_flit = data_flit;
         TX_TAIL: bus.n_tx_flit = tail_flit;
         default: bus.n_tx_flit = '0;
      endcase
   end

   // Latch the word on accept and step the data flit index on each data handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dest_q <= '0;
         data_q <= '0;
         used_q <= CNT_W'(1);
         idx_q  <= '0;
      end else begin
         if (tx_accept) begin
            dest_q <= bus.p_tx_dest;
            data_q <= bus.p_tx_data;
            used_q <= used_w;
         end
         if (tx_state == TX_HEAD && bus.n_tx_ready)
            idx_q <= '0;
         else if (tx_state == TX_DATA && bus.n_tx_ready && !idx_last)
            idx_q <= idx_q + CNT_W'(1);
      end
   end

   noc_ni_rx #(
      .FLIT_W (FLIT_W),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .HDR_TAG(HDR_TAG)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .n_rx_flit (bus.n_rx_flit),
      .n_rx_valid(bus.n_rx_valid),
      .n_rx_last (bus.n_rx_last),
      .n_rx_ready(bus.n_rx_ready),
      .p_rx_valid(bus.p_rx_valid),
      .p_rx_ready(bus.p_rx_ready),
      .p_rx_data (bus.p_rx_data),
      .p_rx_src  (bus.p_rx_src),
      .p_rx_err  (bus.p_rx_err)
   );

endmodule

// File: tb/tb_noc_ni_param.sv
// Directed bench for noc_ni_param (FLIT_W=8, DATA_W=32, ADDR_W=2) with
// TX/RX scoreboards; follows NI_CKSUM_EN to choose expected tail/err values.
module tb_noc_ni_param;
   localparam int FLIT_W = 8;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 2;
`ifdef NI_CKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   typedef struct {
      logic [7:0] flit;
      logic       last;
   } tx_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  src;
      logic        err;
   } rx_exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   tx_exp_t tx_q[$];
   rx_exp_t rx_q[$];
   tx_exp_t tx_e;
   rx_exp_t rx_e;

   always #5 clk = ~clk;

   noc_ni_param_if #(.FLIT_W(FLIT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   noc_ni_param #(
      .FLIT_W (FLIT_W),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .HDR_TAG(6'b101111)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_p_tx_ready"}, bus.p_tx_ready, 1);
      check({tag, "_n_tx_valid"}, bus.n_tx_valid, 0);
      check({tag, "_n_tx_last"},  bus.n_tx_last,  0);
      check({tag, "_n_rx_ready"}, bus.n_rx_ready, 1);
      check({tag, "_p_rx_valid"}, bus.p_rx_valid, 0);
      check({tag, "_p_rx_data"},  bus.p_rx_data,  0);
      check({tag, "_p_rx_src"},   bus.p_rx_src,   0);
      check({tag, "_p_rx_err"},   bus.p_rx_err,   0);
   endtask

   // Reference packetiser: header, data flits up to highest nonzero one, tail.
   task automatic push_tx(input logic [1:0] dest, input logic [31:0] data, output int used);
      logic [7:0] h;
      logic [7:0] x;
      bit found;
      h = {6'b101111, dest};
      used = 1;
      found = 0;
      for (int i = 3; i >= 0; i--) begin
         if (!found && data[i*8 +: 8] != 8'h00) begin
            used = i + 1;
            found = 1;
         end
      end
      tx_q.push_back('{h, 1'b0});
      x = h;
      for (int i = 0; i < used; i++) begin
         tx_q.push_back('{data[i*8 +: 8], 1'b0});
         x = x ^ data[i*8 +: 8];
      end
      tx_q.push_back('{(CK ? x : 8'hFF), 1'b1});
   endtask

   task automatic send_tx(input logic [1:0] dest, input logic [31:0] data);
      int used;
      int lowc;
      bit ok;
      push_tx(dest, data, used);
      bus.p_tx_dest  = dest;
      bus.p_tx_data  = data;
      bus.p_tx_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (bus.p_tx_ready) ok = 1;
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL tx_accept_timeout: observed p_tx_ready=0 expected 1");
      end
      @(posedge clk); #1;
      bus.p_tx_valid = 1'b0;
      lowc = 0;
      ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (bus.p_tx_ready) ok = 1;
         else lowc++;
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL tx_idle_timeout: observed p_tx_ready=0 expected 1");
      end
      check("tx_busy_cycles", lowc, used + 2);
      @(posedge clk); #1;
   endtask

   task automatic rx_flit(input logic [7:0] f, input logic l);
      bit ok;
      ok = 0;
      bus.n_rx_flit  = f;
      bus.n_rx_last  = l;
      bus.n_rx_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (bus.n_rx_ready) ok = 1;
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL rx_ready_timeout: observed n_rx_ready=0 expected 1");
      end
      @(posedge clk); #1;
      bus.n_rx_valid = 1'b0;
      bus.n_rx_last  = 1'b0;
   endtask

   // TX scoreboard: every router handshake pops one expected flit.
   always @(negedge clk) begin
      if (!rst && bus.n_tx_valid && bus.n_tx_ready) begin
         tests++;
         assert (tx_q.size() != 0) else begin
            fails++;
            $error("FAIL tx_extra_flit: observed flit %0h last %0b expected none", bus.n_tx_flit, bus.n_tx_last);
         end
         if (tx_q.size() != 0) begin
            tx_e = tx_q.pop_front();
            check("tx_flit", bus.n_tx_flit, tx_e.flit);
            check("tx_last", bus.n_tx_last, tx_e.last);
         end
      end
   end

   // RX scoreboard: every processor handshake pops one expected word.
   always @(negedge clk) begin
      if (!rst && bus.p_rx_valid && bus.p_rx_ready) begin
         tests++;
         assert (rx_q.size() != 0) else begin
            fails++;
            $error("FAIL rx_extra_word: observed data %0h src %0h expected none", bus.p_rx_data, bus.p_rx_src);
         end
         if (rx_q.size() != 0) begin
            rx_e = rx_q.pop_front();
            check("rx_data", bus.p_rx_data, rx_e.data);
            check("rx_src",  bus.p_rx_src,  rx_e.src);
            check("rx_err",  bus.p_rx_err,  rx_e.err);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int u;
      rst = 1'b1;
      bus.p_tx_valid = 1'b0;
      bus.p_tx_dest  = '0;
      bus.p_tx_data  = '0;
      bus.n_tx_ready = 1'b1;
      bus.n_rx_flit  = '0;
      bus.n_rx_valid = 1'b0;
      bus.n_rx_last  = 1'b0;
      bus.p_rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // T1 / T2: packetising, zero-flit suppression, busy window
      send_tx(2'd2, 32'h11223344);
      send_tx(2'd0, 32'h00000055);
      send_tx(2'd0, 32'h00000000);
      send_tx(2'd3, 32'h00AB0000);

      // T3: router stall while idx=1
      push_tx(2'd2, 32'h11223344, u);
      bus.p_tx_dest  = 2'd2;
      bus.p_tx_data  = 32'h11223344;
      bus.p_tx_valid = 1'b1;
      @(negedge clk);
      check("t3_accept_ready", bus.p_tx_ready, 1);
      @(posedge clk); #1;
      bus.p_tx_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.n_tx_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t3_hold_flit",  bus.n_tx_flit,  8'h33);
         check("t3_hold_valid", bus.n_tx_valid, 1);
         check("t3_hold_busy",  bus.p_tx_ready, 0);
      end
      @(posedge clk); #1;
      bus.n_tx_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("t3_tx_q_drained", tx_q.size(), 0);

      // T4: good packet, processor back-pressure
      rx_q.push_back('{32'h0000BBAA, 2'd1, (CK ? ((8'hBD ^ 8'hAA ^ 8'hBB) != 8'hFF) : 1'b0)});
      bus.p_rx_ready = 1'b0;
      rx_flit(8'hBD, 1'b0);
      rx_flit(8'hAA, 1'b0);
      rx_flit(8'hBB, 1'b0);
      rx_flit(8'hFF, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("t4_n_rx_ready_held", bus.n_rx_ready, 0);
         check("t4_p_rx_valid",      bus.p_rx_valid, 1);
      end
      @(posedge clk); #1;
      bus.p_rx_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_rx_q_drained", rx_q.size(), 0);

      // T5: overflow, dropped packet, stray tail, empty packet, then a clean one
      rx_q.push_back('{32'h44332211, 2'd0, 1'b1});
      rx_flit(8'hBC, 1'b0);
      rx_flit(8'h11, 1'b0);
      rx_flit(8'h22, 1'b0);
      rx_flit(8'h33, 1'b0);
      rx_flit(8'h44, 1'b0);
      rx_flit(8'h55, 1'b0);
      rx_flit(8'hFF, 1'b1);
      rx_flit(8'h00, 1'b0);
      rx_flit(8'hAB, 1'b0);
      rx_flit(8'hCD, 1'b0);
      rx_flit(8'hFF, 1'b1);
      rx_flit(8'hBD, 1'b1);
      rx_q.push_back('{32'h00000000, 2'd1, 1'b1});
      rx_flit(8'hBD, 1'b0);
      rx_flit(8'hBD, 1'b1);
      rx_q.push_back('{32'h00000201, 2'd2, 1'b0});
      rx_flit(8'hBE, 1'b0);
      rx_flit(8'h01, 1'b0);
      rx_flit(8'h02, 1'b0);
      rx_flit(8'hBE ^ 8'h01 ^ 8'h02, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("t5_rx_q_drained", rx_q.size(), 0);

      // T6: reset in the middle of TX DATA and RX DATA
      tx_q.push_back('{8'hBE, 1'b0});
      bus.p_tx_dest  = 2'd2;
      bus.p_tx_data  = 32'h11223344;
      bus.p_tx_valid = 1'b1;
      bus.n_rx_flit  = 8'hBD;
      bus.n_rx_last  = 1'b0;
      bus.n_rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.p_tx_valid = 1'b0;
      bus.n_rx_flit  = 8'hAA;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.n_rx_valid = 1'b0;
      @(negedge clk);
      check_reset("t6_midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      check("t6_tx_q_after_rst", tx_q.size(), 0);
      send_tx(2'd1, 32'hA5000000);
      rx_q.push_back('{32'h00000077, 2'd3, 1'b0});
      rx_flit(8'hBF, 1'b0);
      rx_flit(8'h77, 1'b0);
      rx_flit(8'hBF ^ 8'h77, 1'b1);
      rx_q.push_back('{32'h0000005A, 2'd1, CK});
      rx_flit(8'hBD, 1'b0);
      rx_flit(8'h5A, 1'b0);
      rx_flit((8'hBD ^ 8'h5A) ^ 8'h01, 1'b1);

      repeat (5) @(posedge clk);
      #1;
      check("end_tx_q_empty", tx_q.size(), 0);
      check("end_rx_q_empty", rx_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
